// File: rtl/fir_pkg.sv
// Shared types and elaboration helpers for the streaming FIR filter.
// Holds the FSM state encoding, accumulator sizing and reset coefficients.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT,
        OUT
    } state_t;

    // Width that holds NTAPS full-scale products without overflow.
    function automatic int acc_width(int data_w, int coef_w, int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // Symmetric triangle: 1,2,..,peak,..,2,1.
    function automatic int default_coef(int i, int ntaps);
        return ((i + 1) < (ntaps - i)) ? (i + 1) : (ntaps - i);
    endfunction

endpackage

// File: rtl/fir_stream_if.sv
// Sample stream bundle: one valid/ready channel in, one out.
// The filter is the slave; the surrounding logic is the master.
interface fir_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fir_round_sat.sv
// Combinational post-processing: round-half-up right shift, then
// clamp to the largest unsigned DATA_W value.
module fir_round_sat #(
    parameter int ACC_W  = 19,
    parameter int DATA_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] dout
);
    localparam int RW = ACC_W + 1;
    localparam logic [RW-1:0] MAXV = RW'({DATA_W{1'b1}});

    // One spare bit so adding the rounding constant cannot wrap.
    logic [RW-1:0] r;

    if (SHIFT == 0) begin : g_noshift
        assign r = {1'b0, acc};
    end else begin : g_round
        localparam logic [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
        assign r = ({1'b0, acc} + HALF) >> SHIFT;
    end

    assign dout = (r > MAXV) ? {DATA_W{1'b1}} : r[DATA_W-1:0];

endmodule

// File: rtl/fir_stream.sv
// Streaming direct-form FIR: one sample per handshake, one shared
// multiplier stepped across the taps, rounded and saturated output.
module fir_stream
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 5,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fir_stream_if.slave              s,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     flush,
    output logic                     busy
);
    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
    localparam int PW    = DATA_W + COEF_W;

    state_t            state;
    state_t            state_nx;
    logic [AW-1:0]     idx;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] tap  [NTAPS];
    logic [COEF_W-1:0] coef [NTAPS];
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] rs;
    logic              idle;
    logic              accept;
    logic              last;
    logic              coef_hit;

    assign idle       = (state == IDLE);
    assign s.in_ready = idle;
    assign busy       = !idle;
    // Flush takes priority, so a coincident sample is discarded.
    assign accept     = s.in_valid && idle && !flush;
    assign last       = (idx == AW'(NTAPS - 1));
    assign coef_hit   = coef_we && idle && (int'(coef_addr) < NTAPS);
    assign prod       = PW'(tap[idx]) * PW'(coef[idx]);

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_rs (
        .acc  (acc),
        .dout (rs)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: accept, walk every tap, saturate, wait for drain.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)      state_nx = MAC;
            MAC:     if (last)        state_nx = SAT;
            SAT:                      state_nx = OUT;
            OUT:     if (s.out_ready) state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Multiply-accumulate, one tap per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            acc <= '0;
            idx <= '0;
        end else if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            idx <= last ? '0 : idx + AW'(1);
        end
    end

    // Delay line: shifts on accept, cleared by flush in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) tap[i] <= '0;
        end else if (idle && flush) begin
            for (int i = 0; i < NTAPS; i++) tap[i] <= '0;
        end else if (accept) begin
            tap[0] <= s.in_data;
            for (int i = 1; i < NTAPS; i++) tap[i] <= tap[i-1];
        end
    end

    // Coefficient bank: writable only while no sum is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                coef[i] <= COEF_W'(default_coef(i, NTAPS));
        end else if (coef_hit) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Output register: load in SAT, hold until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.out_data  <= '0;
            s.out_valid <= 1'b0;
        end else if (state == SAT) begin
            s.out_data  <= rs;
            s.out_valid <= 1'b1;
        end else if (state == OUT && s.out_ready) begin
            s.out_valid <= 1'b0;
        end
    end

endmodule
